serial_fs_nand: RTL

//  Bit-serial N-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
//  The per-bit datapath is a full-subtractor cell built only from 2-input NAND gates.
//  A borrow flip-flop chains the bits, giving the subtract counterpart of the NAND adder cells.

---
 rtl/serial_fs_nand_pkg.sv | 17 +
 rtl/serial_fs_nand_cell.sv | 35 +++
 rtl/serial_fs_nand.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_fs_nand_pkg.sv
// ============================================================================
// Module      : serial_fs_nand_pkg
// Description : Shared state encodings for the bit-serial NAND subtractor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_fs_nand_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_UNUSED = 2'd3;

endpackage

`default_nettype wire

// File: rtl/serial_fs_nand_cell.sv
// ============================================================================
// Module      : fs_nand_cell
// Description : Full-subtractor cell (d = x^y^z, bn = borrow) from 2-input NANDs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fs_nand_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bn
);

  logic w_n1, w_n2, w_n3, w_p;
  logic w_m1, w_m2, w_m3;

  // First XOR stage: w_p = x ^ y; w_n3 = ~(~x & y) is reused for the borrow.
  nand g_n1 (w_n1, x, y);
  nand g_n2 (w_n2, x, w_n1);
  nand g_n3 (w_n3, y, w_n1);
  nand g_p  (w_p,  w_n2, w_n3);

  // Second XOR stage: d = w_p ^ z; w_m3 = ~(~w_p & z).
  nand g_m1 (w_m1, w_p, z);
  nand g_m2 (w_m2, w_p, w_m1);
  nand g_m3 (w_m3, z, w_m1);
  nand g_d  (d,    w_m2, w_m3);

  nand g_bn (bn,   w_n3, w_m3);

endmodule

`default_nettype wire

// File: rtl/serial_fs_nand.sv
// ============================================================================
// Module      : serial_fs_nand
// Description : Bit-serial N-bit subtractor (a - b - bin), LSB first, with
//               start/busy/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_fs_nand
  import serial_fs_nand_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_sr_q, a_sr_d;
  logic [N-1:0]     b_sr_q, b_sr_d;
  logic [N-1:0]     r_sr_q, r_sr_d;
  logic             br_q, br_d;
  logic [N-1:0]     diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             w_d, w_bn;

  fs_nand_cell u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .z  (br_q),
    .d  (w_d),
    .bn (w_bn)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Result enters at the MSB so that after N shifts bit 0 sits at r_sr[0].
        r_sr_d = {w_d, r_sr_q[N-1:1]};
        a_sr_d = {1'b0, a_sr_q[N-1:1]};
        b_sr_d = {1'b0, b_sr_q[N-1:1]};
        br_d   = w_bn;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        diff_d  = r_sr_q;
        bout_d  = br_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

`default_nettype wire
